// File: rtl/fifo_sync_flex.sv
// fifo_sync_flex: single-clock parametrised FIFO with selectable standard or
// first-word-fall-through output, programmable almost-full/almost-empty
// thresholds, occupancy count and sticky overflow/underflow flags.
module fifo_sync_flex #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned FWFT          = 0,
    parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cs,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          err_clr,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          rd_valid,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_next;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  ovf_set;
    logic                  unf_set;
    logic                  err_clr_acc;

    // Handshake acceptance, error detection and next occupancy.
    // A write into a full FIFO is only accepted when a read frees a slot in
    // the same cycle; a read from an empty FIFO is never accepted.
    always_comb begin
        rd_acc      = cs & rd_en & ~empty;
        wr_acc      = cs & wr_en & (~full | rd_acc);
        ovf_set     = cs & wr_en & ~wr_acc;
        unf_set     = cs & rd_en & ~rd_acc;
        err_clr_acc = cs & err_clr;
        count_next  = count;
        if (wr_acc && !rd_acc) begin
            count_next = count + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count - CW'(1);
        end
    end

    // Storage array; contents are not reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy and level flags, registered together so the flags always
    // reflect the registered count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else begin
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == CW'(FIFO_DEPTH));
            almost_empty <= (32'(count_next) <= AEMPTY_THRESH);
            almost_full  <= (32'(count_next) >= AFULL_THRESH);
        end
    end

    // Sticky error flags; a new error in the same cycle beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_set | (overflow  & ~err_clr_acc);
            underflow <= unf_set | (underflow & ~err_clr_acc);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue presented directly; meaningless while empty.
            assign data_out = mem[rd_ptr];
            assign rd_valid = 1'b0;
        end else begin : g_std
            // Registered read port: data_out holds until the next accepted read.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_out <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc) begin
                        data_out <= mem[rd_ptr];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Testbench for fifo_sync_flex: one standard-mode and one FWFT instance,
// directed steps with a queue scoreboard of expected read data.
module tb_fifo_sync_flex;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          s_cs = 0, s_wr = 0, s_rd = 0, s_clr = 0;
    logic [DW-1:0] s_din = '0, s_dout;
    logic          s_rv, s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
    logic [CW-1:0] s_cnt;

    logic          f_cs = 0, f_wr = 0, f_rd = 0, f_clr = 0;
    logic [DW-1:0] f_din = '0, f_dout;
    logic          f_rv, f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
    logic [CW-1:0] f_cnt;

    fifo_sync_flex #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(0),
                     .AFULL_THRESH(6), .AEMPTY_THRESH(1)) u_std (
        .clk(clk), .rst(rst), .cs(s_cs), .wr_en(s_wr), .rd_en(s_rd),
        .data_in(s_din), .err_clr(s_clr), .data_out(s_dout), .rd_valid(s_rv),
        .empty(s_empty), .full(s_full), .almost_empty(s_ae), .almost_full(s_af),
        .count(s_cnt), .overflow(s_ovf), .underflow(s_unf));

    fifo_sync_flex #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1),
                     .AFULL_THRESH(6), .AEMPTY_THRESH(1)) u_fw (
        .clk(clk), .rst(rst), .cs(f_cs), .wr_en(f_wr), .rd_en(f_rd),
        .data_in(f_din), .err_clr(f_clr), .data_out(f_dout), .rd_valid(f_rv),
        .empty(f_empty), .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
        .count(f_cnt), .overflow(f_ovf), .underflow(f_unf));

    int vecs = 0;
    int errs = 0;

    // Scoreboards and reference state
    logic [DW-1:0] sq[$];
    logic [DW-1:0] fq[$];
    logic [DW-1:0] s_mdout = '0;
    logic          s_mrv = 0, s_movf = 0, s_munf = 0;
    logic          f_movf = 0, f_munf = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic s_check(input string tag);
        chk({tag, ".count"}, 32'(s_cnt), 32'(sq.size()));
        chk({tag, ".empty"}, 32'(s_empty), 32'(sq.size() == 0));
        chk({tag, ".full"}, 32'(s_full), 32'(sq.size() == DEPTH));
        chk({tag, ".aempty"}, 32'(s_ae), 32'(sq.size() <= 1));
        chk({tag, ".afull"}, 32'(s_af), 32'(sq.size() >= 6));
        chk({tag, ".ovf"}, 32'(s_ovf), 32'(s_movf));
        chk({tag, ".unf"}, 32'(s_unf), 32'(s_munf));
        chk({tag, ".rd_valid"}, 32'(s_rv), 32'(s_mrv));
        chk({tag, ".data_out"}, s_dout, s_mdout);
    endtask

    task automatic f_check(input string tag);
        chk({tag, ".count"}, 32'(f_cnt), 32'(fq.size()));
        chk({tag, ".empty"}, 32'(f_empty), 32'(fq.size() == 0));
        chk({tag, ".full"}, 32'(f_full), 32'(fq.size() == DEPTH));
        chk({tag, ".ovf"}, 32'(f_ovf), 32'(f_movf));
        chk({tag, ".unf"}, 32'(f_unf), 32'(f_munf));
        chk({tag, ".rd_valid"}, 32'(f_rv), 32'(0));
        if (fq.size() > 0) chk({tag, ".head"}, f_dout, fq[0]);
    endtask

    // One clock of standard-instance traffic; expected data pushed on write,
    // popped into the expected data_out on an accepted read.
    task automatic s_op(input logic c, input logic w, input logic r, input logic clr,
                        input logic [DW-1:0] d);
        logic racc, wacc;
        racc = c && r && (sq.size() > 0);
        wacc = c && w && ((sq.size() < DEPTH) || racc);
        if (racc) s_mdout = sq.pop_front();
        if (wacc) sq.push_back(d);
        s_mrv  = racc;
        s_movf = (c && w && !wacc) || (s_movf && !(c && clr));
        s_munf = (c && r && !racc) || (s_munf && !(c && clr));
        s_cs = c; s_wr = w; s_rd = r; s_clr = clr; s_din = d;
        @(posedge clk); #1;
        s_cs = 0; s_wr = 0; s_rd = 0; s_clr = 0;
    endtask

    task automatic f_op(input logic c, input logic w, input logic r, input logic clr,
                        input logic [DW-1:0] d);
        logic racc, wacc;
        racc = c && r && (fq.size() > 0);
        wacc = c && w && ((fq.size() < DEPTH) || racc);
        if (racc) void'(fq.pop_front());
        if (wacc) fq.push_back(d);
        f_movf = (c && w && !wacc) || (f_movf && !(c && clr));
        f_munf = (c && r && !racc) || (f_munf && !(c && clr));
        f_cs = c; f_wr = w; f_rd = r; f_clr = clr; f_din = d;
        @(posedge clk); #1;
        f_cs = 0; f_wr = 0; f_rd = 0; f_clr = 0;
    endtask

    // Assert reset between edges and check outputs before any clock edge.
    task automatic apply_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        sq.delete(); fq.delete();
        s_mdout = '0; s_mrv = 0; s_movf = 0; s_munf = 0;
        f_movf = 0; f_munf = 0;
        s_check(tag);
        f_check({tag, "_fw"});
        chk({tag, ".fw_aempty"}, 32'(f_ae), 32'(1));
        chk({tag, ".fw_afull"}, 32'(f_af), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        apply_reset("rst0");

        // Fill 1..8 watching threshold flags
        for (int i = 1; i <= 8; i++) begin
            s_op(1, 1, 0, 0, DW'(i));
            s_check($sformatf("fill%0d", i));
        end
        s_op(1, 1, 0, 0, 32'd77);
        s_check("wr_full");
        s_op(1, 0, 0, 1, '0);
        s_check("clr_ovf");
        s_op(0, 1, 1, 1, 32'd55);
        s_check("cs_low");

        // Full with simultaneous read and write
        s_op(1, 1, 1, 0, 32'd99);
        s_check("full_rw");
        chk("full_rw.head", s_dout, 32'd1);
        s_op(1, 0, 0, 0, '0);
        s_check("rv_pulse");

        // Drain, ends with 99 after pointer wrap
        for (int i = 0; i < 8; i++) begin
            s_op(1, 0, 1, 0, '0);
            s_check($sformatf("drain%0d", i));
        end
        chk("drain.last", s_dout, 32'd99);
        s_op(1, 0, 1, 0, '0);
        s_check("rd_empty");
        s_op(1, 0, 0, 1, '0);
        s_check("clr_unf");

        // Streaming with simultaneous read+write
        s_op(1, 1, 0, 0, 32'h100);
        for (int i = 1; i <= 4; i++) begin
            s_op(1, 1, 1, 0, DW'(32'h100 + i));
            s_check($sformatf("stream%0d", i));
        end

        // Reset mid-stream at count 5
        for (int i = 0; i < 4; i++) s_op(1, 1, 0, 0, DW'(32'h200 + i));
        s_check("pre_rst");
        f_op(1, 1, 0, 0, 32'h11);
        f_op(1, 1, 0, 0, 32'h22);
        apply_reset("mid_rst");
        s_op(1, 1, 0, 0, 32'd7);
        s_check("post_rst_wr");
        s_op(1, 0, 1, 0, '0);
        s_check("post_rst_rd");
        chk("post_rst.data", s_dout, 32'd7);

        // FWFT instance
        f_op(1, 1, 0, 0, 32'hA5);
        f_check("fw_wr");
        chk("fw_wr.data", f_dout, 32'hA5);
        f_op(1, 0, 1, 0, '0);
        f_check("fw_pop");
        f_op(1, 1, 1, 0, 32'h5A);
        f_check("fw_empty_rw");
        chk("fw_empty_rw.data", f_dout, 32'h5A);
        for (int i = 0; i < 3; i++) f_op(1, 1, 0, 0, DW'(32'h300 + i));
        for (int i = 0; i < 4; i++) begin
            f_op(1, 0, 1, 0, '0);
            f_check($sformatf("fw_drain%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
